uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
Byte FIFO plus drain FSM between the CPU-side UART register write path and the UART sender stage. The CPU pushes TX bytes without polling sender status. The drain FSM pops one byte at a time and issues a single-cycle txen to the sender. It then holds the byte stable until the sender's txstatus signals frame completion.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, at least 2
AW, 4, pointer width, log2(DEPTH)
BUSY_TIMEOUT, 4, cycles to wait for tx_status to fall after tx_en before abandoning the byte

Ports:
CLK  input  1  system clock (same clock as sender sysclk)
Reset_n  input  1  asynchronous active-low reset
wr  input  1  push strobe, one byte per cycle
wdata  input  8  byte to push
clr_flags  input  1  clears the overflow and tx_err sticky flags
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was dropped
tx_err  output  1  sticky: sender never went busy (timeout)
idle  output  1  FIFO empty and FSM in IDLE (all bytes sent)
tx_data  output  8  byte presented to sender txdata
tx_en  output  1  one-cycle start pulse to sender txen
tx_status  input  1  sender txstatus: 1 = idle, 0 = busy

Behaviour:
- Reset (Reset_n low, async): pointers 0, level 0, empty 1, full 0, overflow 0, tx_err 0, tx_data 8'h00, tx_en 0, state IDLE, idle 1. Reset mid-frame discards all queued bytes. The sender is reset by the same Reset_n.
- All outputs are registered or derived only from registers. No combinational path from wr to any output.
- Push: wr high at an edge with full==0 writes wdata at wr_ptr, increments wr_ptr (wraps modulo DEPTH), level+1.
- Push with full==1: byte dropped, overflow set to 1. Full is sampled before a same-cycle pop, so a push is dropped when full even if a pop occurs that edge.
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
- clr_flags clears overflow and tx_err. A same-cycle set takes priority over clear.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if empty==0, pop the head into tx_data, assert tx_en for one cycle, load timeout counter = BUSY_TIMEOUT, go to WAIT_BUSY. Otherwise stay.
- WAIT_BUSY: tx_en forced 0. If tx_status==0, go to WAIT_DONE. Otherwise decrement the counter. At 0: set tx_err, go to IDLE (byte lost).
- WAIT_DONE: wait for tx_status==1, then go to IDLE.
- tx_data is held constant from the pop until the next pop. The sender samples txdata throughout the frame, so it must not change mid-frame.
- Latency: push at edge N into an empty queue with FSM in IDLE gives tx_en=1 and tx_data valid after edge N+1, and tx_en=0 after edge N+2. Back-to-back bytes: the next tx_en follows one cycle after the FSM returns to IDLE.
- tx_status is not assumed to fall in the same cycle as tx_en. The sender drops txstatus one cycle after sampling txen, which fits inside BUSY_TIMEOUT.
- idle = empty & (state==IDLE), registered.

Decomposition:
- Package uart_tx_pkg: state encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2), default DEPTH/AW constants, and bus address constant 32'h40000018 for the TXD write decode done by the parent.
- One sub-module, uart_byte_fifo: synchronous single-clock FIFO (DEPTH×8 register array, wr/rd pointers, level, full/empty, overflow).
- The drain FSM and timeout counter live in uart_tx_queue.

Test Plan:
- Reset then idle: check empty=1, level=0, tx_en=0, tx_data=00, idle=1; no tx_en pulse over 100 cycles.
- Single byte: push 8'hA5 with a sender model that drops tx_status 1 cycle after tx_en and raises it 500 cycles later. Check exactly one tx_en pulse 1 cycle after push, tx_data=A5 stable for the whole frame, and idle=1 after completion.
- Burst: push 0x01..0x10 on 16 consecutive cycles (DEPTH=16). Check full=1 at level 16, overflow=0, and 16 tx_en pulses in order 01..10 with none issued while tx_status=0.
- Overflow: fill 16 entries while the sender is stalled busy, then push 8'hEE. Check the byte is dropped, overflow=1 and level=16. Pulse clr_flags and check overflow=0; EE is never transmitted.
- Timeout: hold tx_status=1 permanently and push 8'h55. Check tx_en pulses once, tx_err=1 after BUSY_TIMEOUT cycles, FSM returns to IDLE, and the next queued byte is issued.
- Reset mid-frame: with 3 bytes queued and the FSM in WAIT_DONE, assert Reset_n low for 1 cycle. Check all outputs return to reset values immediately and no further tx_en pulses occur.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit queue: drain FSM encoding,
// default sizing and the TXD register address decoded by the parent.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int DEF_DEPTH        = 16;
  localparam int DEF_AW           = 4;
  localparam int DEF_BUSY_TIMEOUT = 4;

  localparam logic [31:0] TXD_ADDR = 32'h40000018;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU push path and sender handshake of the UART transmit queue.
// master = CPU/sender side, slave = the queue itself.
interface uart_tx_queue_if
  import uart_tx_pkg::*;
#(
    parameter int AW = DEF_AW
);
    logic          wr;
    logic [7:0]    wdata;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_status;

    modport master (
        output wr, wdata, tx_status,
        input  full, empty, level, tx_data, tx_en
    );

    modport slave (
        input  wr, wdata, tx_status,
        output full, empty, level, tx_data, tx_en
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy flags and a sticky
// overflow flag for pushes attempted while full.
module uart_byte_fifo
  import uart_tx_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          rd,
    input  logic          clr_flags,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic          empty_nxt,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_n;
    logic          push;
    logic          pop;

    // Full is the registered flag, so a push is refused even when a pop
    // frees a slot on the same edge.
    assign push = wr & ~full;
    assign pop  = rd & ~empty;

    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (pop && !push)
            level_n = level - 1'b1;
    end

    assign empty_nxt = (level_n == '0);
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full  <= (level_n == FULL_LVL);
            empty <= empty_nxt;
            if (wr && full)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit queue: byte FIFO drained by an FSM that hands one byte at a
// time to the sender and holds it stable until the frame completes.
module uart_tx_queue
  import uart_tx_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AW           = DEF_AW,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic            CLK,
    input  logic            Reset_n,
    uart_tx_queue_if.slave  bus,
    input  logic            clr_flags,
    output logic            overflow,
    output logic            tx_err,
    output logic            idle
);
    localparam int             CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LOAD = CW'(BUSY_TIMEOUT);

    tx_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic          tx_en_q, tx_en_n;
    logic          pop;
    logic          tmo;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_empty_nxt;
    logic [AW:0]   fifo_level;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .wr        (bus.wr),
        .wdata     (bus.wdata),
        .rd        (pop),
        .clr_flags (clr_flags),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt),
        .level     (fifo_level),
        .overflow  (overflow)
    );

    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;
    assign bus.level   = fifo_level;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_en   = tx_en_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tx_data_n = tx_data_q;
        tx_en_n   = 1'b0;
        pop       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_n = fifo_rdata;
                    tx_en_n   = 1'b1;
                    cnt_n     = TMO_LOAD;
                    state_n   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // The sender may take a cycle to go busy; give up on the byte
                // if it never does within the timeout window.
                if (!bus.tx_status) begin
                    state_n = WAIT_DONE;
                end else if (cnt <= CW'(1)) begin
                    tmo     = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_status)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_err    <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tx_data_q <= tx_data_n;
            tx_en_q   <= tx_en_n;
            if (tmo)
                tx_err <= 1'b1;
            else if (clr_flags)
                tx_err <= 1'b0;
            // Built from next-state values so idle tracks empty & IDLE exactly.
            idle <= fifo_empty_nxt & (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural sender model.
module tb_uart_tx_queue;
    import uart_tx_pkg::*;

    localparam int DEPTH = DEF_DEPTH;
    localparam int AW    = DEF_AW;
    localparam int BT    = DEF_BUSY_TIMEOUT;

    logic CLK = 1'b0;
    logic Reset_n;
    logic clr_flags;
    logic overflow;
    logic tx_err;
    logic idle;

    int total = 0;
    int bad   = 0;

    uart_tx_queue_if #(.AW(AW)) bus ();

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .clr_flags (clr_flags),
        .overflow  (overflow),
        .tx_err    (tx_err),
        .idle      (idle)
    );

    always #5 CLK = ~CLK;

    // Sender model: goes busy the edge after it samples tx_en, stays busy for
    // frame_len cycles. stuck = never goes busy, hold = stays busy forever.
    int   frame_len = 500;
    logic stuck = 1'b0;
    logic hold  = 1'b0;
    int   busy_cnt;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.tx_status <= 1'b1;
            busy_cnt      <= 0;
        end else if (bus.tx_status) begin
            if (bus.tx_en && !stuck) begin
                bus.tx_status <= 1'b0;
                busy_cnt      <= frame_len;
            end
        end else if (!hold) begin
            if (busy_cnt > 1)
                busy_cnt <= busy_cnt - 1;
            else
                bus.tx_status <= 1'b1;
        end
    end

    // Monitor: logs each start pulse and flags protocol violations.
    int         n_pulses  = 0;
    int         busy_err  = 0;
    int         width_err = 0;
    int         stab_err  = 0;
    logic       prev_en   = 1'b0;
    logic [7:0] frame_byte = 8'h00;
    logic [7:0] log_q[$];

    always @(negedge CLK) begin
        if (Reset_n !== 1'b1) begin
            prev_en = 1'b0;
        end else begin
            if (bus.tx_en === 1'b1) begin
                n_pulses++;
                log_q.push_back(bus.tx_data);
                frame_byte = bus.tx_data;
                if (bus.tx_status !== 1'b1) busy_err++;
                if (prev_en) width_err++;
            end else if (bus.tx_status === 1'b0 && bus.tx_data !== frame_byte) begin
                stab_err++;
            end
            prev_en = (bus.tx_en === 1'b1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr    = 1'b1;
        bus.wdata = b;
        tick();
        bus.wr    = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        for (int i = 0; i < maxc && idle !== 1'b1; i++) tick();
        total++;
        if (idle !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle_timeout: idle=%b after %0d cycles, want 1", nm, idle, maxc);
        end
    endtask

    task automatic test_reset();
        int base;
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #20;
        total++; if (bus.empty !== 1'b1)    begin bad++; $display("FAIL rst_empty got=%b want=1", bus.empty); end
        total++; if (bus.full !== 1'b0)     begin bad++; $display("FAIL rst_full got=%b want=0", bus.full); end
        total++; if (bus.level !== 5'd0)    begin bad++; $display("FAIL rst_level got=%0d want=0", bus.level); end
        total++; if (bus.tx_en !== 1'b0)    begin bad++; $display("FAIL rst_tx_en got=%b want=0", bus.tx_en); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", bus.tx_data); end
        total++; if (idle !== 1'b1)         begin bad++; $display("FAIL rst_idle got=%b want=1", idle); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        total++; if (tx_err !== 1'b0)       begin bad++; $display("FAIL rst_tx_err got=%b want=0", tx_err); end
        tick();
        Reset_n = 1'b1;
        base = n_pulses;
        repeat (100) tick();
        total++; if (n_pulses - base !== 0) begin bad++; $display("FAIL rst_quiet_pulses got=%0d want=0", n_pulses - base); end
        total++; if (idle !== 1'b1)         begin bad++; $display("FAIL rst_quiet_idle got=%b want=1", idle); end
    endtask

    task automatic test_single();
        int base, qb, sb;
        frame_len = 500;
        base = n_pulses; qb = log_q.size(); sb = stab_err;
        push(8'hA5);
        total++; if (bus.tx_en !== 1'b0)    begin bad++; $display("FAIL single_en_n0 got=%b want=0", bus.tx_en); end
        total++; if (bus.level !== 5'd1)    begin bad++; $display("FAIL single_level_n0 got=%0d want=1", bus.level); end
        total++; if (idle !== 1'b0)         begin bad++; $display("FAIL single_idle_n0 got=%b want=0", idle); end
        tick();
        total++; if (bus.tx_en !== 1'b1)    begin bad++; $display("FAIL single_en_n1 got=%b want=1", bus.tx_en); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_n1 got=%h want=a5", bus.tx_data); end
        total++; if (bus.level !== 5'd0)    begin bad++; $display("FAIL single_level_n1 got=%0d want=0", bus.level); end
        tick();
        total++; if (bus.tx_en !== 1'b0)     begin bad++; $display("FAIL single_en_n2 got=%b want=0", bus.tx_en); end
        total++; if (bus.tx_status !== 1'b0) begin bad++; $display("FAIL single_busy_n2 got=%b want=0", bus.tx_status); end
        wait_idle(600, "single");
        total++; if (n_pulses - base !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", n_pulses - base); end
        total++; if (log_q.size() <= qb || log_q[qb] !== 8'hA5) begin bad++; $display("FAIL single_logged_byte want=a5 (log size %0d)", log_q.size() - qb); end
        total++; if (stab_err - sb !== 0)   begin bad++; $display("FAIL single_stable got=%0d changes want=0", stab_err - sb); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_held got=%h want=a5", bus.tx_data); end
    endtask

    task automatic test_burst();
        int base, qb, be, we, sb;
        frame_len = 30;
        base = n_pulses; qb = log_q.size(); be = busy_err; we = width_err; sb = stab_err;
        for (int i = 1; i <= 16; i++) push(8'(i));
        // The first byte leaves immediately, so one more push is needed to fill.
        total++; if (bus.level !== 5'd15) begin bad++; $display("FAIL burst_level15 got=%0d want=15", bus.level); end
        total++; if (bus.full !== 1'b0)   begin bad++; $display("FAIL burst_full_at15 got=%b want=0", bus.full); end
        push(8'h11);
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL burst_level16 got=%0d want=16", bus.level); end
        total++; if (bus.full !== 1'b1)   begin bad++; $display("FAIL burst_full got=%b want=1", bus.full); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL burst_overflow got=%b want=0", overflow); end
        wait_idle(1500, "burst");
        total++; if (n_pulses - base !== 17) begin bad++; $display("FAIL burst_pulses got=%0d want=17", n_pulses - base); end
        for (int i = 0; i < 17; i++) begin
            total++;
            if (log_q.size() <= qb + i || log_q[qb + i] !== 8'(i + 1)) begin
                bad++; $display("FAIL burst_order idx=%0d want=%h (log size %0d)", i, 8'(i + 1), log_q.size() - qb);
            end
        end
        total++; if (busy_err - be !== 0)  begin bad++; $display("FAIL burst_en_while_busy got=%0d want=0", busy_err - be); end
        total++; if (width_err - we !== 0) begin bad++; $display("FAIL burst_en_width got=%0d want=0", width_err - we); end
        total++; if (stab_err - sb !== 0)  begin bad++; $display("FAIL burst_stable got=%0d want=0", stab_err - sb); end
    endtask

    task automatic test_overflow();
        int base, qb;
        frame_len = 30;
        hold = 1'b1;
        base = n_pulses; qb = log_q.size();
        push(8'h20);
        repeat (5) tick();
        total++; if (bus.tx_status !== 1'b0) begin bad++; $display("FAIL ovf_sender_busy got=%b want=0", bus.tx_status); end
        for (int i = 0; i < 16; i++) push(8'h21 + 8'(i));
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL ovf_level_full got=%0d want=16", bus.level); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL ovf_pre got=%b want=0", overflow); end
        push(8'hEE);
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL ovf_level_after got=%0d want=16", bus.level); end
        total++; if (bus.full !== 1'b1)   begin bad++; $display("FAIL ovf_full_after got=%b want=1", bus.full); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        clr_flags = 1'b1; push(8'hEE); clr_flags = 1'b0;
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_set_beats_clear got=%b want=1", overflow); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        hold = 1'b0;
        wait_idle(1500, "ovf");
        total++; if (n_pulses - base !== 17) begin bad++; $display("FAIL ovf_pulses got=%0d want=17", n_pulses - base); end
        for (int i = 0; i < 17; i++) begin
            total++;
            if (log_q.size() <= qb + i || log_q[qb + i] !== 8'h20 + 8'(i)) begin
                bad++; $display("FAIL ovf_order idx=%0d want=%h (log size %0d)", i, 8'h20 + 8'(i), log_q.size() - qb);
            end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_final got=%b want=0", overflow); end
    endtask

    task automatic test_timeout();
        int base, qb;
        stuck = 1'b1;
        base = n_pulses; qb = log_q.size();
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL tmo_pre got=%b want=0", tx_err); end
        push(8'h55);
        push(8'h66);
        total++; if (bus.tx_en !== 1'b1)    begin bad++; $display("FAIL tmo_en1 got=%b want=1", bus.tx_en); end
        total++; if (bus.tx_data !== 8'h55) begin bad++; $display("FAIL tmo_data1 got=%h want=55", bus.tx_data); end
        total++; if (bus.level !== 5'd1)    begin bad++; $display("FAIL tmo_level got=%0d want=1", bus.level); end
        repeat (BT - 1) tick();
        total++; if (tx_err !== 1'b0)       begin bad++; $display("FAIL tmo_early got=%b want=0", tx_err); end
        total++; if (bus.tx_en !== 1'b0)    begin bad++; $display("FAIL tmo_en_low got=%b want=0", bus.tx_en); end
        tick();
        total++; if (tx_err !== 1'b1)       begin bad++; $display("FAIL tmo_err got=%b want=1", tx_err); end
        tick();
        total++; if (bus.tx_en !== 1'b1)    begin bad++; $display("FAIL tmo_en2 got=%b want=1", bus.tx_en); end
        total++; if (bus.tx_data !== 8'h66) begin bad++; $display("FAIL tmo_data2 got=%h want=66", bus.tx_data); end
        wait_idle(20, "tmo");
        total++; if (n_pulses - base !== 2) begin bad++; $display("FAIL tmo_pulses got=%0d want=2", n_pulses - base); end
        total++; if (log_q.size() < qb + 2 || log_q[qb] !== 8'h55 || log_q[qb + 1] !== 8'h66) begin
            bad++; $display("FAIL tmo_order want=55,66 (log size %0d)", log_q.size() - qb);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", tx_err); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        frame_len = 500;
        for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
        repeat (5) tick();
        total++; if (bus.level !== 5'd3)     begin bad++; $display("FAIL mid_level_pre got=%0d want=3", bus.level); end
        total++; if (bus.tx_status !== 1'b0) begin bad++; $display("FAIL mid_busy_pre got=%b want=0", bus.tx_status); end
        total++; if (bus.tx_data !== 8'h71)  begin bad++; $display("FAIL mid_data_pre got=%h want=71", bus.tx_data); end
        Reset_n = 1'b0;
        #2;
        total++; if (bus.level !== 5'd0)    begin bad++; $display("FAIL mid_level got=%0d want=0", bus.level); end
        total++; if (bus.empty !== 1'b1)    begin bad++; $display("FAIL mid_empty got=%b want=1", bus.empty); end
        total++; if (bus.tx_en !== 1'b0)    begin bad++; $display("FAIL mid_tx_en got=%b want=0", bus.tx_en); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got=%h want=00", bus.tx_data); end
        total++; if (idle !== 1'b1)         begin bad++; $display("FAIL mid_idle got=%b want=1", idle); end
        tick();
        Reset_n = 1'b1;
        base = n_pulses;
        repeat (100) tick();
        total++; if (n_pulses - base !== 0) begin bad++; $display("FAIL mid_no_pulse got=%0d want=0", n_pulses - base); end
        total++; if (idle !== 1'b1)         begin bad++; $display("FAIL mid_idle_after got=%b want=1", idle); end
    endtask

    initial begin
        bus.wr    = 1'b0;
        bus.wdata = 8'h00;
        clr_flags = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
